pipe_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB segment registers).
- Arbitrates stall sources by priority and produces per-segment enable/flush signals.
- Tracks outstanding instruction fetches and discards the responses of fetches cancelled by an exception or ERET redirect.
- Carries the branch-delay-slot flag across IF bubbles so the segment register feeding ID sees the correct id_branch.

---
 rtl/pipe_ctrl_pkg.sv | 56 +++++
 rtl/pipe_ctrl_fetch_cancel_ctr.sv | 69 ++++++
 rtl/pipe_ctrl.sv | 89 ++++++++
 tb/tb_pipe_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: stall-source priority,
// fetch-cancel FSM states and the per-segment control bundle.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_FLUSH,
      SRC_MEM,
      SRC_DIV,
      SRC_LDUSE,
      SRC_FETCH
   } stall_src_e;

   typedef enum logic {
      ST_RUN,
      ST_DRAIN
   } fetch_state_e;

   // en/flush bit order: [3]=IF/ID, [2]=ID/EX, [1]=EX/MEM, [0]=MEM/WB
   typedef struct packed {
      logic       redirect;
      logic       pc_en;
      logic [3:0] en;
      logic [3:0] flush;
   } seg_ctrl_t;

   function automatic stall_src_e prio_encode(input logic flush, input logic mem,
                                              input logic div, input logic lduse,
                                              input logic fetch);
      if (flush)      return SRC_FLUSH;
      else if (mem)   return SRC_MEM;
      else if (div)   return SRC_DIV;
      else if (lduse) return SRC_LDUSE;
      else if (fetch) return SRC_FETCH;
      else            return SRC_NONE;
   endfunction

   // Every stall holds the stages upstream of its source and bubbles the segment just below it.
   function automatic seg_ctrl_t seg_ctrl(input stall_src_e src);
      seg_ctrl_t c;
      c.redirect = 1'b0;
      c.pc_en    = 1'b1;
      c.en       = 4'b1111;
      c.flush    = 4'b0000;
      case (src)
         SRC_FLUSH: begin c.redirect = 1'b1; c.flush = 4'b1111; end
         SRC_MEM:   begin c.pc_en = 1'b0; c.en = 4'b0001; c.flush = 4'b0001; end
         SRC_DIV:   begin c.pc_en = 1'b0; c.en = 4'b0011; c.flush = 4'b0010; end
         SRC_LDUSE: begin c.pc_en = 1'b0; c.en = 4'b0111; c.flush = 4'b0100; end
         SRC_FETCH: begin c.pc_en = 1'b0; c.en = 4'b1111; c.flush = 4'b1000; end
         default:   ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipe_ctrl_fetch_cancel_ctr.sv
// Outstanding-fetch tracker: counts in-flight instruction requests and, after a
// redirect, marks the responses of the cancelled fetches for discard.
module fetch_cancel_ctr
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_OUTST = 2,
   parameter int CNT_W     = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic flush,
   input  logic inst_req_fire,
   input  logic inst_data_ok,
   output logic fetch_allow,
   output logic inst_discard
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

   fetch_state_e     state_q;
   logic [CNT_W-1:0] outst_q;
   logic [CNT_W-1:0] outst_d;
   logic [CNT_W-1:0] cancel_q;
   logic [CNT_W:0]   outst_sum;

   always_comb begin
      outst_sum = {1'b0, outst_q} + {{CNT_W{1'b0}}, inst_req_fire};
      if (inst_data_ok && outst_sum == '0) outst_d = '0;
      else outst_d = CNT_W'(outst_sum - {{CNT_W{1'b0}}, inst_data_ok});
   end

   assign fetch_allow  = (outst_q < MAX_CNT) | inst_data_ok;
   assign inst_discard = (state_q == ST_DRAIN) & inst_data_ok;

   // outst_d is the count that survives this cycle, i.e. exactly the responses a redirect must cancel.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_RUN;
         outst_q  <= '0;
         cancel_q <= '0;
      end else begin
         outst_q <= outst_d;
         case (state_q)
            ST_RUN: begin
               if (flush && outst_d != '0) begin
                  state_q  <= ST_DRAIN;
                  cancel_q <= outst_d;
               end
            end
            ST_DRAIN: begin
               if (flush) begin
                  cancel_q <= outst_d;
                  if (outst_d == '0) state_q <= ST_RUN;
               end else if (inst_data_ok) begin
                  cancel_q <= cancel_q - CNT_W'(1);
                  if (cancel_q == CNT_W'(1)) state_q <= ST_RUN;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   a_no_overissue: assert property (@(posedge clk) disable iff (!resetn)
      !(inst_req_fire && !fetch_allow));
   a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
      !(inst_data_ok && outst_q == '0));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: priority-arbitrates stall
// sources into segment enables/flushes and carries the delay-slot flag over IF bubbles.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_OUTST = 2,
   parameter int CNT_W     = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic if_wait,
   input  logic mem_wait,
   input  logic ex_div_busy,
   input  logic id_load_use,
   input  logic id_branch,
   input  logic mem_exc,
   input  logic mem_eret,
   input  logic inst_req_fire,
   input  logic inst_data_ok,
   output logic fetch_allow,
   output logic inst_discard,
   output logic redirect,
   output logic pc_en,
   output logic if_id_en,
   output logic id_ex_en,
   output logic ex_mem_en,
   output logic mem_wb_en,
   output logic if_id_flush,
   output logic id_ex_flush,
   output logic ex_mem_flush,
   output logic mem_wb_flush,
   output logic id_bd_in
);

   stall_src_e src;
   seg_ctrl_t  ctrl;
   logic       flush;
   logic       bd_pending_q;
   logic       bd_pending_d;

   assign flush = mem_exc | mem_eret;

   fetch_cancel_ctr #(
      .MAX_OUTST (MAX_OUTST),
      .CNT_W     (CNT_W)
   ) u_fetch_cancel_ctr (
      .clk           (clk),
      .resetn        (resetn),
      .flush         (flush),
      .inst_req_fire (inst_req_fire),
      .inst_data_ok  (inst_data_ok),
      .fetch_allow   (fetch_allow),
      .inst_discard  (inst_discard)
   );

   always_comb begin
      src  = prio_encode(flush, mem_wait, ex_div_busy, id_load_use, if_wait | inst_discard);
      ctrl = seg_ctrl(src);
   end

   assign redirect     = ctrl.redirect;
   assign pc_en        = ctrl.pc_en;
   assign if_id_en     = ctrl.en[3];
   assign id_ex_en     = ctrl.en[2];
   assign ex_mem_en    = ctrl.en[1];
   assign mem_wb_en    = ctrl.en[0];
   assign if_id_flush  = ctrl.flush[3];
   assign id_ex_flush  = ctrl.flush[2];
   assign ex_mem_flush = ctrl.flush[1];
   assign mem_wb_flush = ctrl.flush[0];

   // A branch leaving ID behind an IF bubble leaves its slot flag pending until a real fetch lands.
   always_comb begin
      bd_pending_d = bd_pending_q;
      case (src)
         SRC_FLUSH, SRC_NONE: bd_pending_d = 1'b0;
         SRC_FETCH:           bd_pending_d = bd_pending_q | id_branch;
         default:             ;
      endcase
   end

   assign id_bd_in = id_branch | bd_pending_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) bd_pending_q <= 1'b0;
      else         bd_pending_q <= bd_pending_d;
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-scenario tasks with a segment-control
// scoreboard and an in-order fetch-tag scoreboard for cancelled responses.
module tb_pipe_ctrl;

   logic clk, resetn;
   logic if_wait, mem_wait, ex_div_busy, id_load_use, id_branch, mem_exc, mem_eret;
   logic inst_req_fire, inst_data_ok;
   logic fetch_allow, inst_discard, redirect, pc_en;
   logic if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, id_bd_in;
   logic [9:0] seg_o;

   int checks = 0;
   int passed = 0;
   logic [9:0] seg_q[$];
   bit         tag_q[$];

   localparam logic [9:0] S_NONE = 10'b0_1_1111_0000;
   localparam logic [9:0] S_P1   = 10'b1_1_1111_1111;
   localparam logic [9:0] S_P2   = 10'b0_0_0001_0001;
   localparam logic [9:0] S_P3   = 10'b0_0_0011_0010;
   localparam logic [9:0] S_P4   = 10'b0_0_0111_0100;
   localparam logic [9:0] S_P5   = 10'b0_0_1111_1000;

   pipe_ctrl #(.MAX_OUTST(3), .CNT_W(2)) dut (
      .clk(clk), .resetn(resetn),
      .if_wait(if_wait), .mem_wait(mem_wait), .ex_div_busy(ex_div_busy),
      .id_load_use(id_load_use), .id_branch(id_branch),
      .mem_exc(mem_exc), .mem_eret(mem_eret),
      .inst_req_fire(inst_req_fire), .inst_data_ok(inst_data_ok),
      .fetch_allow(fetch_allow), .inst_discard(inst_discard), .redirect(redirect), .pc_en(pc_en),
      .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
      .id_bd_in(id_bd_in)
   );

   assign seg_o = {redirect, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // bits: exc, eret, mem_wait, div_busy, load_use, if_wait, id_branch
   task automatic drive_srcs(input logic [6:0] v);
      {mem_exc, mem_eret, mem_wait, ex_div_busy, id_load_use, if_wait, id_branch} = v;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      drive_srcs(7'd0);
      inst_req_fire = 1'b0;
      inst_data_ok  = 1'b0;
      #2;
      checks++;
      if (seg_o !== S_NONE) $display("FAIL reset_seg: got %b expected %b", seg_o, S_NONE);
      else passed++;
      checks++;
      if ({fetch_allow, inst_discard, id_bd_in} !== 3'b100)
         $display("FAIL reset_flags: got %b expected 100", {fetch_allow, inst_discard, id_bd_in});
      else passed++;
      @(negedge clk);
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_idle();
      logic [9:0] exp_seg;
      for (int i = 0; i < 2; i++) begin
         drive_srcs(7'd0);
         seg_q.push_back(S_NONE);
         @(negedge clk);
         exp_seg = seg_q.pop_front();
         checks++;
         if (seg_o !== exp_seg) $display("FAIL idle_seg[%0d]: got %b expected %b", i, seg_o, exp_seg);
         else passed++;
         checks++;
         if ({fetch_allow, inst_discard} !== 2'b10)
            $display("FAIL idle_fetch[%0d]: got %b expected 10", i, {fetch_allow, inst_discard});
         else passed++;
         tick();
      end
   endtask

   task automatic test_mem_div();
      logic [16:0] t [5] = '{ {7'b0011000, S_P2}, {7'b0011000, S_P2}, {7'b0011000, S_P2},
                              {7'b0001000, S_P3}, {7'b0000000, S_NONE} };
      logic [9:0] exp_seg;
      foreach (t[i]) begin
         drive_srcs(t[i][16:10]);
         seg_q.push_back(t[i][9:0]);
         @(negedge clk);
         exp_seg = seg_q.pop_front();
         checks++;
         if (seg_o !== exp_seg) $display("FAIL mem_div[%0d]: got %b expected %b", i, seg_o, exp_seg);
         else passed++;
         tick();
      end
   endtask

   task automatic test_load_use();
      logic [16:0] t [2] = '{ {7'b0000100, S_P4}, {7'b0000000, S_NONE} };
      logic [9:0] exp_seg;
      foreach (t[i]) begin
         drive_srcs(t[i][16:10]);
         seg_q.push_back(t[i][9:0]);
         @(negedge clk);
         exp_seg = seg_q.pop_front();
         checks++;
         if (seg_o !== exp_seg) $display("FAIL load_use[%0d]: got %b expected %b", i, seg_o, exp_seg);
         else passed++;
         tick();
      end
   endtask

   task automatic test_priority();
      logic [16:0] t [6] = '{ {7'b1111111, S_P1}, {7'b0101110, S_P1}, {7'b0001110, S_P3},
                              {7'b0000110, S_P4}, {7'b0000010, S_P5}, {7'b0000000, S_NONE} };
      logic [9:0] exp_seg;
      foreach (t[i]) begin
         drive_srcs(t[i][16:10]);
         seg_q.push_back(t[i][9:0]);
         @(negedge clk);
         exp_seg = seg_q.pop_front();
         checks++;
         if (seg_o !== exp_seg) $display("FAIL priority[%0d]: got %b expected %b", i, seg_o, exp_seg);
         else passed++;
         tick();
      end
   endtask

   task automatic test_branch_delay();
      logic [17:0] t [9] = '{ {7'b0000011, S_P5, 1'b1}, {7'b0000011, S_P5, 1'b1},
                              {7'b0000000, S_NONE, 1'b1}, {7'b0000000, S_NONE, 1'b0},
                              {7'b0000011, S_P5, 1'b1}, {7'b0000100, S_P4, 1'b1},
                              {7'b0000010, S_P5, 1'b1}, {7'b1000000, S_P1, 1'b1},
                              {7'b0000000, S_NONE, 1'b0} };
      logic [9:0] exp_seg;
      foreach (t[i]) begin
         drive_srcs(t[i][17:11]);
         seg_q.push_back(t[i][10:1]);
         @(negedge clk);
         exp_seg = seg_q.pop_front();
         checks++;
         if (seg_o !== exp_seg) $display("FAIL bd_seg[%0d]: got %b expected %b", i, seg_o, exp_seg);
         else passed++;
         checks++;
         if (id_bd_in !== t[i][0]) $display("FAIL bd_in[%0d]: got %b expected %b", i, id_bd_in, t[i][0]);
         else passed++;
         tick();
      end
   endtask

   // rows: fire, data_ok, exc, eret, expected fetch_allow, expected segment controls
   task automatic test_fetch_limit();
      logic [14:0] t [8] = '{ {5'b10001, S_NONE}, {5'b10001, S_NONE}, {5'b10001, S_NONE},
                              {5'b00000, S_NONE}, {5'b11001, S_NONE}, {5'b01001, S_NONE},
                              {5'b01001, S_NONE}, {5'b01001, S_NONE} };
      logic fire_v, ok_v, exc_v, eret_v, fa_e, disc_e;
      logic [9:0] seg_e, exp_seg;
      foreach (t[i]) begin
         {fire_v, ok_v, exc_v, eret_v, fa_e, seg_e} = t[i];
         {inst_req_fire, inst_data_ok, mem_exc, mem_eret} = {fire_v, ok_v, exc_v, eret_v};
         seg_q.push_back(seg_e);
         disc_e = (ok_v && tag_q.size() > 0) ? tag_q.pop_front() : 1'b0;
         @(negedge clk);
         exp_seg = seg_q.pop_front();
         checks++;
         if (seg_o !== exp_seg) $display("FAIL limit_seg[%0d]: got %b expected %b", i, seg_o, exp_seg);
         else passed++;
         checks++;
         if (fetch_allow !== fa_e) $display("FAIL limit_allow[%0d]: got %b expected %b", i, fetch_allow, fa_e);
         else passed++;
         checks++;
         if (inst_discard !== disc_e) $display("FAIL limit_discard[%0d]: got %b expected %b", i, inst_discard, disc_e);
         else passed++;
         if (fire_v) tag_q.push_back(1'b0);
         if (exc_v | eret_v) foreach (tag_q[k]) tag_q[k] = 1'b1;
         tick();
      end
      {inst_req_fire, inst_data_ok, mem_exc, mem_eret} = 4'b0000;
   endtask

   task automatic test_cancel_drain();
      logic [14:0] t [7] = '{ {5'b10001, S_NONE}, {5'b10001, S_NONE}, {5'b10101, S_P1},
                              {5'b11001, S_P5}, {5'b01001, S_P5}, {5'b01001, S_P5},
                              {5'b01001, S_NONE} };
      logic fire_v, ok_v, exc_v, eret_v, fa_e, disc_e;
      logic [9:0] seg_e, exp_seg;
      foreach (t[i]) begin
         {fire_v, ok_v, exc_v, eret_v, fa_e, seg_e} = t[i];
         {inst_req_fire, inst_data_ok, mem_exc, mem_eret} = {fire_v, ok_v, exc_v, eret_v};
         seg_q.push_back(seg_e);
         disc_e = (ok_v && tag_q.size() > 0) ? tag_q.pop_front() : 1'b0;
         @(negedge clk);
         exp_seg = seg_q.pop_front();
         checks++;
         if (seg_o !== exp_seg) $display("FAIL cancel_seg[%0d]: got %b expected %b", i, seg_o, exp_seg);
         else passed++;
         checks++;
         if (fetch_allow !== fa_e) $display("FAIL cancel_allow[%0d]: got %b expected %b", i, fetch_allow, fa_e);
         else passed++;
         checks++;
         if (inst_discard !== disc_e) $display("FAIL cancel_discard[%0d]: got %b expected %b", i, inst_discard, disc_e);
         else passed++;
         if (fire_v) tag_q.push_back(1'b0);
         if (exc_v | eret_v) foreach (tag_q[k]) tag_q[k] = 1'b1;
         tick();
      end
      {inst_req_fire, inst_data_ok, mem_exc, mem_eret} = 4'b0000;
   endtask

   task automatic test_drain_reload();
      logic [14:0] t [10] = '{ {5'b10001, S_NONE}, {5'b10001, S_NONE}, {5'b00101, S_P1},
                               {5'b01001, S_P5}, {5'b10001, S_NONE}, {5'b00011, S_P1},
                               {5'b01001, S_P5}, {5'b01001, S_P5}, {5'b10001, S_NONE},
                               {5'b01001, S_NONE} };
      logic fire_v, ok_v, exc_v, eret_v, fa_e, disc_e;
      logic [9:0] seg_e, exp_seg;
      foreach (t[i]) begin
         {fire_v, ok_v, exc_v, eret_v, fa_e, seg_e} = t[i];
         {inst_req_fire, inst_data_ok, mem_exc, mem_eret} = {fire_v, ok_v, exc_v, eret_v};
         seg_q.push_back(seg_e);
         disc_e = (ok_v && tag_q.size() > 0) ? tag_q.pop_front() : 1'b0;
         @(negedge clk);
         exp_seg = seg_q.pop_front();
         checks++;
         if (seg_o !== exp_seg) $display("FAIL reload_seg[%0d]: got %b expected %b", i, seg_o, exp_seg);
         else passed++;
         checks++;
         if (fetch_allow !== fa_e) $display("FAIL reload_allow[%0d]: got %b expected %b", i, fetch_allow, fa_e);
         else passed++;
         checks++;
         if (inst_discard !== disc_e) $display("FAIL reload_discard[%0d]: got %b expected %b", i, inst_discard, disc_e);
         else passed++;
         if (fire_v) tag_q.push_back(1'b0);
         if (exc_v | eret_v) foreach (tag_q[k]) tag_q[k] = 1'b1;
         tick();
      end
      {inst_req_fire, inst_data_ok, mem_exc, mem_eret} = 4'b0000;
   endtask

   task automatic test_reset_mid_drain();
      logic [2:0] pre [3] = '{3'b100, 3'b100, 3'b101};
      logic fa_e;
      foreach (pre[i]) begin
         {inst_req_fire, inst_data_ok, mem_exc} = pre[i];
         tick();
      end
      {inst_req_fire, inst_data_ok, mem_exc} = 3'b010;
      #1;
      checks++;
      if (inst_discard !== 1'b1) $display("FAIL drain_pre_reset: got %b expected 1", inst_discard);
      else passed++;
      resetn = 1'b0;
      #1;
      checks++;
      if (inst_discard !== 1'b0) $display("FAIL async_reset_discard: got %b expected 0", inst_discard);
      else passed++;
      checks++;
      if (seg_o !== S_NONE) $display("FAIL async_reset_seg: got %b expected %b", seg_o, S_NONE);
      else passed++;
      inst_data_ok = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      tick();
      tag_q.delete();
      for (int i = 0; i < 4; i++) begin
         fa_e = (i < 3);
         inst_req_fire = fa_e;
         @(negedge clk);
         checks++;
         if (fetch_allow !== fa_e) $display("FAIL post_reset_allow[%0d]: got %b expected %b", i, fetch_allow, fa_e);
         else passed++;
         tick();
      end
      inst_req_fire = 1'b0;
      inst_data_ok  = 1'b1;
      repeat (3) tick();
      inst_data_ok  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_mem_div();
      test_load_use();
      test_priority();
      test_branch_delay();
      test_fetch_limit();
      test_cancel_drain();
      test_drain_reload();
      test_reset_mid_drain();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
